// File: rtl/bitmap_ctrl.sv
// -----------------------------------------------------------------------------
// bitmap_ctrl
//
// Command front-end for a host/plane ownership bitmap kept in an external
// single-port memory (one row per plane, one bit per host). Only one command is
// in flight at a time.
//
// Commands (i_cmd_op):
//   00 SET       read row, write it back with bit[host] = 1
//   01 CLR       read row, write it back with bit[host] = 0
//   10 QUERY     read row
//   11 SCAN_FREE read rows 0.. until an all-zero row is found or rows run out
//
// Ports:
//   i_clk, i_rst_n                   clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready          command handshake
//   i_cmd_op, i_cmd_host, i_cmd_plane command fields
//   o_rsp_valid/i_rsp_ready          response handshake; fields held until taken
//   o_rsp_mask                       row value (pre-modify for SET/CLR)
//   o_rsp_plane                      plane the response refers to
//   o_rsp_hit                        SCAN_FREE found a zero row
//   o_rsp_err                        command rejected, no memory access
//   o_mem_cs_n, o_mem_we_n           registered memory strobes, active low
//   o_mem_addr, o_mem_wdata          registered memory address / write data
//   i_mem_rdata                      read data, valid in the cycle of the read
// -----------------------------------------------------------------------------
`ifndef MAX_HOST_NUMBER
`define MAX_HOST_NUMBER 4
`endif
`ifndef MAX_PLANE_NUMBER
`define MAX_PLANE_NUMBER 6
`endif

module bitmap_ctrl #(
    parameter int MAX_HOST_NUMBER  = `MAX_HOST_NUMBER,
    parameter int MAX_PLANE_NUMBER = `MAX_PLANE_NUMBER,
    localparam int HOST_BIT_WIDTH  = $clog2(MAX_HOST_NUMBER),
    localparam int ADDR_BIT_WIDTH  = $clog2(MAX_PLANE_NUMBER)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [1:0]                 i_cmd_op,
    input  logic [HOST_BIT_WIDTH-1:0]  i_cmd_host,
    input  logic [ADDR_BIT_WIDTH-1:0]  i_cmd_plane,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [MAX_HOST_NUMBER-1:0] o_rsp_mask,
    output logic [ADDR_BIT_WIDTH-1:0]  o_rsp_plane,
    output logic                       o_rsp_hit,
    output logic                       o_rsp_err,
    output logic                       o_mem_cs_n,
    output logic                       o_mem_we_n,
    output logic [ADDR_BIT_WIDTH-1:0]  o_mem_addr,
    output logic [MAX_HOST_NUMBER-1:0] o_mem_wdata,
    input  logic [MAX_HOST_NUMBER-1:0] i_mem_rdata
);

    localparam logic [1:0] OP_SET   = 2'b00;
    localparam logic [1:0] OP_CLR   = 2'b01;
    localparam logic [1:0] OP_QUERY = 2'b10;
    localparam logic [1:0] OP_SCAN  = 2'b11;

    localparam logic [ADDR_BIT_WIDTH-1:0] LAST_PLANE = ADDR_BIT_WIDTH'(MAX_PLANE_NUMBER - 1);

    typedef enum logic [2:0] {IDLE, RD, WR, SCAN, RSP} state_t;

    state_t                      state_q, state_d;
    logic [1:0]                  op_q, op_d;
    logic [HOST_BIT_WIDTH-1:0]   host_q, host_d;
    logic                        cs_n_q, cs_n_d;
    logic                        we_n_q, we_n_d;
    logic [ADDR_BIT_WIDTH-1:0]   addr_q, addr_d;
    logic [MAX_HOST_NUMBER-1:0]  wdata_q, wdata_d;
    logic [MAX_HOST_NUMBER-1:0]  rsp_mask_q, rsp_mask_d;
    logic [ADDR_BIT_WIDTH-1:0]   rsp_plane_q, rsp_plane_d;
    logic                        rsp_hit_q, rsp_hit_d;
    logic                        rsp_err_q, rsp_err_d;

    logic                        cmd_bad;
    logic [MAX_HOST_NUMBER-1:0]  row_mod;

    // Plane range applies to everything but SCAN_FREE; host range only to SET/CLR.
    always_comb begin
        cmd_bad = 1'b0;
        if (i_cmd_op != OP_SCAN && int'(i_cmd_plane) >= MAX_PLANE_NUMBER) begin
            cmd_bad = 1'b1;
        end
        if (!i_cmd_op[1] && int'(i_cmd_host) >= MAX_HOST_NUMBER) begin
            cmd_bad = 1'b1;
        end
    end

    // Row being read with the addressed host bit forced to the command's value.
    always_comb begin
        row_mod         = i_mem_rdata;
        row_mod[host_q] = (op_q == OP_SET);
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        host_d      = host_q;
        cs_n_d      = 1'b1;
        we_n_d      = 1'b1;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_mask_d  = rsp_mask_q;
        rsp_plane_d = rsp_plane_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    op_d        = i_cmd_op;
                    host_d      = i_cmd_host;
                    rsp_plane_d = i_cmd_plane;
                    rsp_mask_d  = '0;
                    rsp_hit_d   = 1'b0;
                    rsp_err_d   = 1'b0;
                    if (i_cmd_op == OP_SCAN) begin
                        state_d = SCAN;
                        addr_d  = '0;
                        cs_n_d  = 1'b0;
                    end else if (cmd_bad) begin
                        state_d   = RSP;
                        rsp_err_d = 1'b1;
                    end else begin
                        state_d = RD;
                        addr_d  = i_cmd_plane;
                        cs_n_d  = 1'b0;
                    end
                end
            end
            RD: begin
                rsp_mask_d = i_mem_rdata;
                if (op_q == OP_QUERY) begin
                    state_d = RSP;
                end else begin
                    state_d = WR;
                    cs_n_d  = 1'b0;
                    we_n_d  = 1'b0;
                    wdata_d = row_mod;
                end
            end
            WR: begin
                state_d = RSP;
            end
            SCAN: begin
                if (i_mem_rdata == '0) begin
                    state_d     = RSP;
                    rsp_hit_d   = 1'b1;
                    rsp_plane_d = addr_q;
                    rsp_mask_d  = '0;
                end else if (addr_q == LAST_PLANE) begin
                    state_d     = RSP;
                    rsp_hit_d   = 1'b0;
                    rsp_plane_d = addr_q;
                    rsp_mask_d  = i_mem_rdata;
                end else begin
                    addr_d = addr_q + ADDR_BIT_WIDTH'(1);
                    cs_n_d = 1'b0;
                end
            end
            RSP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_q        <= OP_SET;
            host_q      <= '0;
            cs_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_mask_q  <= '0;
            rsp_plane_q <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            op_q        <= op_d;
            host_q      <= host_d;
            cs_n_q      <= cs_n_d;
            we_n_q      <= we_n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_mask_q  <= rsp_mask_d;
            rsp_plane_q <= rsp_plane_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign o_cmd_ready = (state_q == IDLE);
    assign o_rsp_valid = (state_q == RSP);
    assign o_rsp_mask  = rsp_mask_q;
    assign o_rsp_plane = rsp_plane_q;
    assign o_rsp_hit   = rsp_hit_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_mem_cs_n  = cs_n_q;
    assign o_mem_we_n  = we_n_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_bitmap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bitmap_ctrl
//
// Bench for bitmap_ctrl with 4 hosts and 6 planes. A behavioural bitmap memory
// (cleared by reset, combinational read) sits on the memory port and logs every
// read and write. A table of commands with hand-computed responses, latencies
// and memory traffic is applied in order; response backpressure and a reset in
// the middle of a write are exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_bitmap_ctrl;

    localparam int HOSTS  = 4;
    localparam int PLANES = 6;

    localparam logic [1:0] OP_SET  = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_QRY  = 2'b10;
    localparam logic [1:0] OP_SCAN = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [1:0] cmd_host = 2'b00;
    logic [2:0] cmd_plane = 3'b000;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [3:0] rsp_mask;
    logic [2:0] rsp_plane;
    logic       rsp_hit;
    logic       rsp_err;
    logic       mem_cs_n;
    logic       mem_we_n;
    logic [2:0] mem_addr;
    logic [3:0] mem_wdata;
    logic [3:0] mem_rdata;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    bitmap_ctrl #(
        .MAX_HOST_NUMBER (HOSTS),
        .MAX_PLANE_NUMBER(PLANES)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_op   (cmd_op),
        .i_cmd_host (cmd_host),
        .i_cmd_plane(cmd_plane),
        .o_rsp_valid(rsp_valid),
        .i_rsp_ready(rsp_ready),
        .o_rsp_mask (rsp_mask),
        .o_rsp_plane(rsp_plane),
        .o_rsp_hit  (rsp_hit),
        .o_rsp_err  (rsp_err),
        .o_mem_cs_n (mem_cs_n),
        .o_mem_we_n (mem_we_n),
        .o_mem_addr (mem_addr),
        .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bitmap memory model; a poison value is returned when no read is driven.
    logic [3:0]  mem [8];
    int unsigned rd_log[$];
    int unsigned wr_addr_log[$];
    int unsigned wr_data_log[$];

    assign mem_rdata = (!mem_cs_n && mem_we_n) ? mem[mem_addr] : 4'b1010;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mem[i] <= 4'b0000;
        end else if (!mem_cs_n) begin
            if (mem_we_n) begin
                rd_log.push_back(32'(mem_addr));
            end else begin
                mem[mem_addr] <= mem_wdata;
                wr_addr_log.push_back(32'(mem_addr));
                wr_data_log.push_back(32'(mem_wdata));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [1:0] host;
        logic [2:0] plane;
        logic [3:0] mask;
        logic [2:0] rplane;
        logic       hit;
        logic       err;
        int         lat;
        int         reads;
        int         writes;
        logic [3:0] wdata;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] op, input logic [1:0] host,
                                input logic [2:0] plane, input logic [3:0] mask,
                                input logic [2:0] rplane, input logic hit, input logic err,
                                input int lat, input int reads, input int writes,
                                input logic [3:0] wdata);
        vec_t v;
        v.op = op; v.host = host; v.plane = plane; v.mask = mask; v.rplane = rplane;
        v.hit = hit; v.err = err; v.lat = lat; v.reads = reads; v.writes = writes;
        v.wdata = wdata;
        return v;
    endfunction

    // Issue one command (called at a negedge with the DUT idle) and wait for its response.
    task automatic issue(input logic [1:0] op, input logic [1:0] host, input logic [2:0] plane,
                         output int t_acc, output int lat);
        int waited;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_host  = host;
        cmd_plane = plane;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        t_acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!rsp_valid && (cyc - t_acc) < 20) @(negedge clk);
        lat = cyc - t_acc;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int r0, w0, t_acc, lat, nr, nw;
        r0 = rd_log.size();
        w0 = wr_addr_log.size();
        issue(v.op, v.host, v.plane, t_acc, lat);
        chk($sformatf("v%0d.latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d.rsp_valid", idx), 32'(rsp_valid), 32'd1);
        chk($sformatf("v%0d.mask", idx), 32'(rsp_mask), 32'(v.mask));
        chk($sformatf("v%0d.plane", idx), 32'(rsp_plane), 32'(v.rplane));
        chk($sformatf("v%0d.hit", idx), 32'(rsp_hit), 32'(v.hit));
        chk($sformatf("v%0d.err", idx), 32'(rsp_err), 32'(v.err));
        chk($sformatf("v%0d.cmd_ready_in_rsp", idx), 32'(cmd_ready), 32'd0);
        nr = rd_log.size() - r0;
        nw = wr_addr_log.size() - w0;
        chk($sformatf("v%0d.reads", idx), 32'(nr), 32'(v.reads));
        chk($sformatf("v%0d.writes", idx), 32'(nw), 32'(v.writes));
        for (int i = 0; i < nr && i < v.reads; i++) begin
            chk($sformatf("v%0d.rd_addr%0d", idx, i), rd_log[r0 + i],
                (v.op == OP_SCAN) ? 32'(i) : 32'(v.plane));
        end
        if (nw > 0 && v.writes > 0) begin
            chk($sformatf("v%0d.wr_addr", idx), wr_addr_log[w0], 32'(v.plane));
            chk($sformatf("v%0d.wr_data", idx), wr_data_log[w0], 32'(v.wdata));
        end
        @(negedge clk);
        chk($sformatf("v%0d.idle_after", idx), 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        int   t_acc, lat, w0;
        logic [3:0] hold_mask;

        // op, host, plane | mask, rsp_plane, hit, err, latency, reads, writes, wdata
        vecs.push_back(mk(OP_SET,  2, 3, 4'b0000, 3, 0, 0, 3, 1, 1, 4'b0100));
        vecs.push_back(mk(OP_SET,  0, 3, 4'b0100, 3, 0, 0, 3, 1, 1, 4'b0101));
        vecs.push_back(mk(OP_QRY,  0, 3, 4'b0101, 3, 0, 0, 2, 1, 0, 4'b0000));
        vecs.push_back(mk(OP_CLR,  2, 3, 4'b0101, 3, 0, 0, 3, 1, 1, 4'b0001));
        vecs.push_back(mk(OP_CLR,  2, 3, 4'b0001, 3, 0, 0, 3, 1, 1, 4'b0001));
        vecs.push_back(mk(OP_QRY,  0, 7, 4'b0000, 7, 0, 1, 1, 0, 0, 4'b0000));
        vecs.push_back(mk(OP_SET,  1, 0, 4'b0000, 0, 0, 0, 3, 1, 1, 4'b0010));
        vecs.push_back(mk(OP_SET,  1, 1, 4'b0000, 1, 0, 0, 3, 1, 1, 4'b0010));
        vecs.push_back(mk(OP_SCAN, 0, 0, 4'b0000, 2, 1, 0, 4, 3, 0, 4'b0000));
        vecs.push_back(mk(OP_SET,  0, 0, 4'b0010, 0, 0, 0, 3, 1, 1, 4'b0011));
        vecs.push_back(mk(OP_SET,  0, 1, 4'b0010, 1, 0, 0, 3, 1, 1, 4'b0011));
        vecs.push_back(mk(OP_SET,  0, 2, 4'b0000, 2, 0, 0, 3, 1, 1, 4'b0001));
        vecs.push_back(mk(OP_SET,  0, 3, 4'b0001, 3, 0, 0, 3, 1, 1, 4'b0001));
        vecs.push_back(mk(OP_SET,  0, 4, 4'b0000, 4, 0, 0, 3, 1, 1, 4'b0001));
        vecs.push_back(mk(OP_SET,  0, 5, 4'b0000, 5, 0, 0, 3, 1, 1, 4'b0001));
        vecs.push_back(mk(OP_SCAN, 0, 0, 4'b0001, 5, 0, 0, 7, 6, 0, 4'b0000));
        vecs.push_back(mk(OP_QRY,  0, 6, 4'b0000, 6, 0, 1, 1, 0, 0, 4'b0000));

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst.cs_n", 32'(mem_cs_n), 32'd1);
        chk("rst.we_n", 32'(mem_we_n), 32'd1);
        chk("rst.addr", 32'(mem_addr), 32'd0);
        chk("rst.wdata", 32'(mem_wdata), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_mask", 32'(rsp_mask), 32'd0);
        chk("rst.rsp_plane", 32'(rsp_plane), 32'd0);
        chk("rst.rsp_hit", 32'(rsp_hit), 32'd0);
        chk("rst.rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Response backpressure: plane 0 holds 0011 at this point.
        rsp_ready = 1'b0;
        issue(OP_QRY, 2'd0, 3'd0, t_acc, lat);
        chk("bp.latency", 32'(lat), 32'd2);
        hold_mask = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp.valid%0d", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp.mask%0d", i), 32'(rsp_mask), 32'(hold_mask));
            chk($sformatf("bp.plane%0d", i), 32'(rsp_plane), 32'd0);
            chk($sformatf("bp.hit_err%0d", i), 32'({rsp_hit, rsp_err}), 32'd0);
            chk($sformatf("bp.cmd_ready%0d", i), 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        chk("bp.cmd_ready_same_cycle", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("bp.rsp_valid_after", 32'(rsp_valid), 32'd0);
        chk("bp.cmd_ready_after", 32'(cmd_ready), 32'd1);

        // Reset asserted in the middle of the WR cycle of a SET.
        w0 = wr_addr_log.size();
        cmd_valid = 1'b1;
        cmd_op    = OP_SET;
        cmd_host  = 2'd3;
        cmd_plane = 3'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("wrrst.in_wr", 32'({mem_cs_n, mem_we_n}), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("wrrst.cs_n", 32'(mem_cs_n), 32'd1);
        chk("wrrst.we_n", 32'(mem_we_n), 32'd1);
        chk("wrrst.rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("wrrst.no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("wrrst.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("wrrst.no_write", 32'(wr_addr_log.size() - w0), 32'd0);
        run_vec(100, mk(OP_QRY, 0, 4, 4'b0000, 4, 0, 0, 2, 1, 0, 4'b0000));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
